// File: rtl/alu_cmd_ctrl.sv
// Command front-end for a registered ALU: latches one command, strobes the ALU,
// then streams the double-width result low byte first. Optional WAIT timeout via ALU_CMD_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | ready for a command (CMD_READY=1 except in the cycle after a reset edge)
// ISSUE   | single-cycle ALU_EN strobe with the latched command
// WAIT    | waiting for ALU_OUT_VALID; optionally bounded to 8 cycles
// SEND_LO | TX_DATA = result low half, held until TX_READY
// SEND_HI | TX_DATA = result high half, held until TX_READY
module alu_cmd_ctrl #(
    parameter int OPER_WIDTH = 8,
    parameter int OUT_WIDTH  = 2 * OPER_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  CMD_VALID,
    output logic                  CMD_READY,
    input  logic [3:0]            CMD_FUN,
    input  logic [OPER_WIDTH-1:0] CMD_A,
    input  logic [OPER_WIDTH-1:0] CMD_B,
    output logic                  ALU_EN,
    output logic [3:0]            ALU_FUN,
    output logic [OPER_WIDTH-1:0] ALU_A,
    output logic [OPER_WIDTH-1:0] ALU_B,
    input  logic [OUT_WIDTH-1:0]  ALU_OUT,
    input  logic                  ALU_OUT_VALID,
    output logic [OPER_WIDTH-1:0] TX_DATA,
    output logic                  TX_VALID,
    input  logic                  TX_READY,
    output logic                  BUSY,
    output logic                  ERR
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_SEND_LO,
        S_SEND_HI
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic                    rst_q;
    logic [3:0]              fun_q;
    logic [OPER_WIDTH-1:0]   a_q;
    logic [OPER_WIDTH-1:0]   b_q;
    logic [OUT_WIDTH-1:0]    result_q;
    logic                    accept;
    logic                    timeout;

    // rst_q keeps CMD_READY low for the cycle that follows a reset edge
    always_ff @(posedge CLK) begin
        rst_q <= RST;
    end

    assign accept = (state == S_IDLE) && !rst_q && CMD_VALID;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            fun_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
        end else if (accept) begin
            fun_q <= CMD_FUN;
            a_q   <= CMD_A;
            b_q   <= CMD_B;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            result_q <= '0;
        end else if ((state == S_WAIT) && ALU_OUT_VALID) begin
            result_q <= ALU_OUT;
        end
    end

`ifdef ALU_CMD_TIMEOUT_EN
    logic [2:0] wait_cnt;
    logic       err_q;

    assign timeout = (state == S_WAIT) && !ALU_OUT_VALID && (wait_cnt == 3'd0);

    // Down-counter reloads outside WAIT so every WAIT entry gets the full 8 cycles
    always_ff @(posedge CLK) begin
        if (RST) begin
            wait_cnt <= 3'd0;
            err_q    <= 1'b0;
        end else begin
            err_q <= timeout;
            if (state != S_WAIT) begin
                wait_cnt <= 3'd7;
            end else if (!ALU_OUT_VALID) begin
                wait_cnt <= wait_cnt - 3'd1;
            end
        end
    end

    assign ERR = err_q;
`else
    assign timeout = 1'b0;
    assign ERR     = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (!rst_q && CMD_VALID) state_nxt = S_ISSUE;
            S_ISSUE:   state_nxt = S_WAIT;
            S_WAIT: begin
                if (ALU_OUT_VALID) begin
                    state_nxt = S_SEND_LO;
                end else if (timeout) begin
                    state_nxt = S_IDLE;
                end
            end
            S_SEND_LO: if (TX_READY) state_nxt = S_SEND_HI;
            S_SEND_HI: if (TX_READY) state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        CMD_READY = 1'b0;
        ALU_EN    = 1'b0;
        TX_VALID  = 1'b0;
        TX_DATA   = '0;
        BUSY      = 1'b1;
        case (state)
            S_IDLE: begin
                CMD_READY = !rst_q;
                BUSY      = 1'b0;
            end
            S_ISSUE:   ALU_EN = 1'b1;
            S_SEND_LO: begin
                TX_VALID = 1'b1;
                TX_DATA  = result_q[OPER_WIDTH-1:0];
            end
            S_SEND_HI: begin
                TX_VALID = 1'b1;
                TX_DATA  = result_q[OUT_WIDTH-1:OPER_WIDTH];
            end
            default: ;
        endcase
    end

    assign ALU_FUN = fun_q;
    assign ALU_A   = a_q;
    assign ALU_B   = b_q;

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Directed bench for alu_cmd_ctrl: expected TX bytes go into a queue that a
// negedge monitor drains on every TX handshake. Honours ALU_CMD_TIMEOUT_EN.
module tb_alu_cmd_ctrl;
    localparam int OW = 8;
    localparam int RW = 16;

    logic          CLK = 1'b0;
    logic          RST;
    logic          CMD_VALID;
    logic          CMD_READY;
    logic [3:0]    CMD_FUN;
    logic [OW-1:0] CMD_A;
    logic [OW-1:0] CMD_B;
    logic          ALU_EN;
    logic [3:0]    ALU_FUN;
    logic [OW-1:0] ALU_A;
    logic [OW-1:0] ALU_B;
    logic [RW-1:0] ALU_OUT;
    logic          ALU_OUT_VALID;
    logic [OW-1:0] TX_DATA;
    logic          TX_VALID;
    logic          TX_READY;
    logic          BUSY;
    logic          ERR;

    int            n_checks = 0;
    int            n_fail = 0;
    logic [OW-1:0] exp_q[$];
    int            accepts = 0;
    int            alu_en_cycles = 0;
    logic          alu_mute = 1'b0;
    logic          force_vld = 1'b0;
    logic          model_vld = 1'b0;
    logic [RW-1:0] model_out = '0;

    always #5 CLK = ~CLK;

    alu_cmd_ctrl #(.OPER_WIDTH(OW), .OUT_WIDTH(RW)) dut (
        .CLK(CLK), .RST(RST),
        .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_FUN(CMD_FUN),
        .CMD_A(CMD_A), .CMD_B(CMD_B),
        .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN), .ALU_A(ALU_A), .ALU_B(ALU_B),
        .ALU_OUT(ALU_OUT), .ALU_OUT_VALID(ALU_OUT_VALID),
        .TX_DATA(TX_DATA), .TX_VALID(TX_VALID), .TX_READY(TX_READY),
        .BUSY(BUSY), .ERR(ERR)
    );

    // One-cycle registered ALU: add, sub, mul; all other codes give zero
    always @(posedge CLK) begin
        if (ALU_EN && !alu_mute) begin
            model_vld <= 1'b1;
            case (ALU_FUN)
                4'h0:    model_out <= RW'(ALU_A) + RW'(ALU_B);
                4'h1:    model_out <= RW'(ALU_A) - RW'(ALU_B);
                4'h2:    model_out <= RW'(ALU_A) * RW'(ALU_B);
                default: model_out <= '0;
            endcase
        end else begin
            model_vld <= 1'b0;
        end
    end

    assign ALU_OUT_VALID = model_vld | force_vld;
    assign ALU_OUT       = model_out;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic void fail_bound(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: wait bound expired", name);
    endfunction

    always @(negedge CLK) begin
        if (!RST) begin
            if (CMD_VALID && CMD_READY) accepts++;
            if (ALU_EN) alu_en_cycles++;
            if (TX_VALID && TX_READY) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL tx_unexpected: got 0x%0h, expected no byte", TX_DATA);
                end else begin
                    check("tx_data", 32'(TX_DATA), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic issue(input logic [3:0] fun, input logic [OW-1:0] a, input logic [OW-1:0] b);
        for (int i = 0; i < 50 && !CMD_READY; i++) tick();
        if (!CMD_READY) fail_bound("cmd_ready_wait");
        CMD_VALID = 1'b1;
        CMD_FUN   = fun;
        CMD_A     = a;
        CMD_B     = b;
        tick();
        CMD_VALID = 1'b0;
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 80 && (BUSY || exp_q.size() != 0); i++) tick();
        if (BUSY || exp_q.size() != 0) fail_bound(name);
    endtask

    initial begin
        int q_at_second;
        RST = 1'b1; CMD_VALID = 1'b0; CMD_FUN = '0; CMD_A = '0; CMD_B = '0; TX_READY = 1'b1;
        tick();
        tick();
        check("rst_cmd_ready", 32'(CMD_READY), 0);
        check("rst_busy", 32'(BUSY), 0);
        check("rst_alu_en", 32'(ALU_EN), 0);
        check("rst_alu_ab", 32'({ALU_FUN, ALU_A, ALU_B}), 0);
        check("rst_tx", 32'({TX_VALID, TX_DATA}), 0);
        check("rst_err", 32'(ERR), 0);
        RST = 1'b0;
        tick();
        check("ready_after_rst", 32'(CMD_READY), 1);

        // addition with minimum-latency timing
        alu_en_cycles = 0;
        exp_q.push_back(8'h08); exp_q.push_back(8'h00);
        issue(4'h0, 8'h05, 8'h03);
        check("add_alu_en_n1", 32'(ALU_EN), 1);
        check("add_alu_ops", 32'({ALU_FUN, ALU_A, ALU_B}), 32'h00503);
        check("add_busy", 32'({BUSY, CMD_READY}), 32'b10);
        tick();
        check("add_n2", 32'({ALU_EN, TX_VALID}), 0);
        tick();
        check("add_n3_tx", 32'({TX_VALID, TX_DATA}), 32'h108);
        wait_done("add_done");
        check("add_idle", 32'(BUSY), 0);
        check("add_alu_en_once", alu_en_cycles, 1);

        exp_q.push_back(8'h01); exp_q.push_back(8'hFE);
        issue(4'h2, 8'hFF, 8'hFF);
        wait_done("mul_done");

        exp_q.push_back(8'h00); exp_q.push_back(8'h00);
        issue(4'hF, 8'h12, 8'h34);
        check("fun_f_pass", 32'({ALU_FUN, ALU_A, ALU_B}), 32'hF1234);
        wait_done("fun_f_done");

        // backpressure in SEND_LO
        TX_READY = 1'b0;
        exp_q.push_back(8'h01); exp_q.push_back(8'hFE);
        issue(4'h2, 8'hFF, 8'hFF);
        for (int i = 0; i < 20 && !TX_VALID; i++) tick();
        if (!TX_VALID) fail_bound("bp_tx_valid");
        for (int i = 0; i < 5; i++) begin
            check("bp_hold", 32'({TX_VALID, TX_DATA}), 32'h101);
            check("bp_ops_stable", 32'({ALU_FUN, ALU_A, ALU_B}), 32'h2FFFF);
            tick();
        end
        check("bp_queue_untouched", exp_q.size(), 2);
        TX_READY = 1'b1;
        wait_done("bp_done");

        // CMD_VALID held through a full transaction
        accepts = 0;
        q_at_second = -1;
        repeat (2) begin exp_q.push_back(8'h05); exp_q.push_back(8'h00); end
        CMD_FUN = 4'h1; CMD_A = 8'h09; CMD_B = 8'h04; CMD_VALID = 1'b1;
        for (int i = 0; i < 60 && accepts < 2; i++) begin
            tick();
            if (accepts == 2 && q_at_second < 0) q_at_second = exp_q.size();
        end
        CMD_VALID = 1'b0;
        wait_done("busy_rej_done");
        repeat (3) tick();
        check("busy_rej_accepts", accepts, 2);
        check("busy_rej_second_after_idle", q_at_second, 2);

        // reset during WAIT, then a stale ALU_OUT_VALID
        alu_mute = 1'b1;
        issue(4'h0, 8'h01, 8'h01);
        repeat (3) tick();
        check("wait_busy", 32'({BUSY, TX_VALID}), 32'b10);
`ifndef ALU_CMD_TIMEOUT_EN
        repeat (10) tick();
        check("wait_indefinite", 32'({BUSY, ERR, TX_VALID}), 32'b100);
`endif
        RST = 1'b1;
        tick();
        check("midrst_state", 32'({CMD_READY, BUSY, ALU_EN, TX_VALID}), 0);
        check("midrst_ops", 32'({ALU_FUN, ALU_A, ALU_B}), 0);
        RST = 1'b0;
        tick();
        check("midrst_ready", 32'(CMD_READY), 1);
        force_vld = 1'b1;
        tick();
        force_vld = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("stale_vld_ignored", 32'({TX_VALID, BUSY}), 0);
            tick();
        end
        alu_mute = 1'b0;

`ifdef ALU_CMD_TIMEOUT_EN
        begin
            int err_first;
            int err_cnt;
            err_first = -1;
            err_cnt = 0;
            alu_mute = 1'b1;
            issue(4'h0, 8'h02, 8'h02);
            for (int i = 1; i <= 14; i++) begin
                tick();
                if (ERR) begin
                    err_cnt++;
                    if (err_first < 0) err_first = i;
                end
            end
            check("timeout_err_cycle", err_first, 9);
            check("timeout_err_once", err_cnt, 1);
            check("timeout_idle", 32'({BUSY, CMD_READY}), 32'b01);
            alu_mute = 1'b0;
        end
`endif

        exp_q.push_back(8'h08); exp_q.push_back(8'h00);
        issue(4'h0, 8'h05, 8'h03);
        wait_done("recover_done");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout, expected test completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/alu_cmd_ctrl.md
ALU_CMD_CTRL -- requirements
Module: alu_cmd_ctrl

Interface
REQ-001 SHALL have parameter OPER_WIDTH, default 8, operand width driven to the ALU.
REQ-002 SHALL have parameter OUT_WIDTH, default 2*OPER_WIDTH, ALU result width; OUT_WIDTH SHALL equal 2*OPER_WIDTH.
REQ-003 SHALL have port CLK  in  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port RST  in  1  reset, synchronous and active-high.
REQ-005 SHALL have port CMD_VALID  in  1  command request.
REQ-006 SHALL have port CMD_READY  out  1  command acceptance.
REQ-007 SHALL have port CMD_FUN  in  4  ALU function code.
REQ-008 SHALL have ports CMD_A and CMD_B  in  OPER_WIDTH  operands.
REQ-009 SHALL have port ALU_EN  out  1  ALU enable strobe.
REQ-010 SHALL have port ALU_FUN  out  4  function code to the ALU.
REQ-011 SHALL have ports ALU_A and ALU_B  out  OPER_WIDTH  operands to the ALU.
REQ-012 SHALL have port ALU_OUT  in  OUT_WIDTH  registered ALU result.
REQ-013 SHALL have port ALU_OUT_VALID  in  1  ALU result valid.
REQ-014 SHALL have port TX_DATA  out  OPER_WIDTH  result byte stream.
REQ-015 SHALL have port TX_VALID  out  1; TX_READY  in  1  stream handshake.
REQ-016 SHALL have port BUSY  out  1  high whenever the FSM is not in IDLE.
REQ-017 SHALL have port ERR  out  1  one-cycle timeout pulse.

Function
REQ-018 SHALL implement FSM states IDLE, ISSUE, WAIT, SEND_LO and SEND_HI, all outputs registered or decoded from state only.
REQ-019 CMD_READY SHALL be 1 only in IDLE; a command is accepted on an edge with CMD_VALID=1 and CMD_READY=1, latching CMD_FUN/CMD_A/CMD_B and moving to ISSUE.
REQ-020 CMD_VALID outside IDLE SHALL be ignored, with no queuing.
REQ-021 ALU_FUN/ALU_A/ALU_B SHALL show latched values from the cycle after acceptance until the return to IDLE, unchanged in between.
REQ-022 ALU_EN SHALL be 1 for exactly the single ISSUE cycle, and ISSUE SHALL always advance to WAIT.
REQ-023 In WAIT, an edge with ALU_OUT_VALID=1 SHALL capture ALU_OUT into a result register and move to SEND_LO.
REQ-024 ALU_OUT_VALID SHALL be ignored in IDLE, SEND_LO and SEND_HI.
REQ-025 Minimum latency SHALL be: accept at edge N, ALU_EN high in cycle N+1, result capture at edge N+2 for a 1-cycle ALU, TX_VALID high from cycle N+3.
REQ-026 SEND_LO SHALL drive TX_VALID=1 with TX_DATA=result[OPER_WIDTH-1:0], holding until an edge with TX_READY=1, then go to SEND_HI.
REQ-027 SEND_HI SHALL drive TX_VALID=1 with TX_DATA=result[OUT_WIDTH-1:OPER_WIDTH], holding until TX_READY=1, then go to IDLE.
REQ-028 TX_DATA SHALL remain stable while TX_VALID=1 and TX_READY=0; TX_VALID SHALL be 0 in every other state.
REQ-029 The function code SHALL be passed through unmodified, including the unused code 4'b1111 (two bytes 0x00 expected back).

Reset
REQ-030 RST=1 at an edge SHALL, from any state, force IDLE and set CMD_READY=0 for that cycle; ALU_EN, ALU_FUN, ALU_A, ALU_B, TX_DATA, TX_VALID, BUSY, ERR, the result register and the timeout counter SHALL all be 0.
REQ-031 CMD_READY SHALL be 1 from the first cycle after RST deasserts.
REQ-032 Reset mid-operation SHALL abandon the command, and any stale ALU_OUT_VALID arriving later SHALL be ignored.

Configuration
REQ-033 Macro ALU_CMD_TIMEOUT_EN, when defined, SHALL add a 3-bit WAIT counter; 8 consecutive WAIT cycles without ALU_OUT_VALID SHALL pulse ERR=1 for one cycle and return to IDLE with no TX bytes.
REQ-034 Without ALU_CMD_TIMEOUT_EN, WAIT SHALL last indefinitely, ERR SHALL be constant 0, and no counter SHALL exist.

Verification
REQ-035 Addition case: FUN=0000, A=0x05, B=0x03, TX_READY=1 -> TX_DATA 0x08 then 0x00, BUSY low after 2nd byte.
REQ-036 Multiplication case: FUN=0010, A=0xFF, B=0xFF -> TX_DATA 0x01 then 0xFE.
REQ-037 Backpressure case: TX_READY=0 for 5 cycles in SEND_LO -> TX_VALID=1 and TX_DATA=0x01 stable, no SEND_HI until TX_READY=1.
REQ-038 Busy rejection case: CMD_VALID=1 with FUN=0001, A=0x09, B=0x04 held through one full transaction -> accepted once, 2nd accepted only after IDLE, bytes 0x05,0x00 per transaction.
REQ-039 Reset case: RST=1 for one cycle during WAIT, then ALU_OUT_VALID pulse -> no TX_VALID, CMD_READY=1 the cycle after RST falls.
REQ-040 Timeout case: with ALU_CMD_TIMEOUT_EN, ALU_OUT_VALID never asserted -> ERR=1 exactly once, 8 cycles after entering WAIT, then IDLE.
